feature_baseline_tracker: RTL and testbench
===========================================

Name: feature_baseline_tracker

Overview:
- Per-feature baseline estimator that produces the `*_base` value and qualifier consumed by the threshold comparator (`out >= base * scale`).
- Consumes the same feature stream as the comparator (line length, nonlinear energy, band power).
- Forms block means over 2^LOG2_WIN valid samples and folds each mean into an exponential moving average.
- Windows overlapping a detection (`freeze`) are discarded, so seizure activity never inflates the baseline.

Parameters:
- IN_W, 72, signed feature input width
- BASE_W, 50, signed baseline output width
- LOG2_WIN, 8, log2 of samples per averaging window (>=1)
- EMA_SHIFT, 3, EMA weight as a right shift; 0 means base = window mean

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- feat_in  in  IN_W  signed feature sample
- feat_valid  in  1  feat_in valid this cycle
- freeze  in  1  detection active; taints the window in progress
- clear  in  1  synchronous restart of baseline learning
- base_out  out  BASE_W  signed baseline
- base_valid  out  1  base_out holds a learned value
- base_update  out  1  one-cycle pulse: base_out changed this cycle
- win_discard  out  1  one-cycle pulse: completed window rejected

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: base_out=0, base_valid=0, base_update=0, win_discard=0, sample count=0, accumulator=0, taint=0, state=WARMUP.
- States:
  - WARMUP: no baseline yet.
  - TRACK: baseline valid.
  - Only clean window completion moves WARMUP to TRACK. Only rst or clear return to WARMUP.
- Accumulation:
  - Each cycle with feat_valid=1 adds sign-extended feat_in to an accumulator of width IN_W+LOG2_WIN. The accumulator cannot overflow.
  - A counter (LOG2_WIN bits) increments per accepted sample and wraps to 0 on the 2^LOG2_WIN-th sample.
  - At the wrap, the accumulator reloads with 0, or with the new sample if one is accepted in the following cycle.
- Taint: set if freeze=1 in any cycle from the cycle of a window's first accepted sample through the cycle of its last accepted sample, inclusive. Cleared at window completion. freeze outside a window (count=0, no valid) has no effect.
- Mean: accumulator arithmetic-shifted right by LOG2_WIN (floor), then saturated to the signed BASE_W range [-2^(BASE_W-1), 2^(BASE_W-1)-1].
- Pipeline timing (last sample of a window accepted in cycle n):
  - Mean and taint are registered at the end of cycle n.
  - The update is applied at the end of cycle n+1.
  - New outputs are visible in cycle n+2.
- Clean window, WARMUP: base_out=mean, base_valid=1, base_update=1 for cycle n+2; go to TRACK.
- Clean window, TRACK:
  - diff = mean - base_out, computed at BASE_W+1 bits.
  - base_out += (diff >>> EMA_SHIFT), arithmetic shift (floor toward -inf). The result stays in BASE_W range with no wrap.
  - base_update=1 for cycle n+2, even if the increment is 0.
- Tainted window: base_out and base_valid unchanged, win_discard=1 for cycle n+2, state unchanged.
- Back-to-back windows: the update path accepts a new mean every cycle, so full-rate feat_valid loses no samples.
- clear:
  - Counter, accumulator and taint go to 0; base_valid=0; state=WARMUP.
  - Any in-flight pipeline result is cancelled, so no base_update or win_discard follows.
  - base_out holds its value.
  - A sample presented in the same cycle as clear is dropped.
  - clear has priority over window completion in the same cycle.
- rst mid-operation: identical to clear, plus base_out=0.
- base_out never changes except in a base_update cycle or on rst.

Decomposition:
- Package `seizure_det_pkg`:
  - tracker state enum {WARMUP, TRACK}
  - default widths FEAT_W=72, BASE_W=50, LL_W=41, LL_BASE_W=34
  - a saturating-resize function shared with other feature blocks
- Sub-module `window_accum`: owns the accumulator, counter and taint. It outputs a mean strobe, the saturated mean and the taint flag, with its own clear input.
- The top level owns the EMA stage, the FSM and the output registers.

Test Plan:
All scenarios use LOG2_WIN=2, EMA_SHIFT=1, default widths.
- Reset: hold rst 2 cycles -> base_out=0, base_valid=0, no pulses.
- Warmup: samples 10,20,30,40 on consecutive cycles n-3..n -> in cycle n+2, base_out=25, base_valid=1, base_update pulse exactly 1 cycle.
- EMA, positive and negative step:
  - Next window 45×4 -> base_out=35.
  - Following window 30×4 -> diff=-5, >>>1 = -3 -> base_out=32.
  - Gapped feat_valid (idle cycles between samples) gives identical results.
- Freeze: freeze=1 for one cycle during the 2nd sample of a TRACK window -> win_discard pulse in n+2, base_out unchanged, no base_update. Freeze during a WARMUP window -> base_valid stays 0.
- Saturation: warmup with 4 samples of 2^60 -> base_out = 2^49-1. Samples of -2^60 -> base_out = -2^49.
- Clear race: clear asserted in the same cycle as a window's last sample -> no base_update, base_valid=0, base_out holds. The next 4 samples 8,8,8,8 -> base_out=8, state TRACK.

Source files
------------

// File: rtl/seizure_det_pkg.sv
// Shared types, default widths and helpers for the seizure-detection feature blocks.
package seizure_det_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    TRACK  = 1'b1
  } tracker_state_t;

  localparam int FEAT_W    = 72;
  localparam int BASE_W    = 50;
  localparam int LL_W      = 41;
  localparam int LL_BASE_W = 34;

  // Working width of sat_resize; callers sign-extend into it and truncate the result.
  localparam int SAT_W = 128;

  function automatic logic signed [SAT_W-1:0] sat_resize(
    input logic signed [SAT_W-1:0] x,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (out_w - 1)) - one;
    lo  = ~hi;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/window_accum.sv
// Block accumulator: sums 2^LOG2_WIN accepted samples, tracks freeze taint, and
// emits a registered, saturated window mean with a one-cycle strobe.
module window_accum
  import seizure_det_pkg::*;
#(
  parameter int IN_W     = FEAT_W,
  parameter int OUT_W    = seizure_det_pkg::BASE_W,
  parameter int LOG2_WIN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [IN_W-1:0]  feat_in,
  input  logic                    feat_valid,
  input  logic                    freeze,
  output logic                    mean_stb,
  output logic signed [OUT_W-1:0] mean,
  output logic                    mean_taint
);

  localparam int ACC_W = IN_W + LOG2_WIN;

  logic signed [ACC_W-1:0]  acc_reg;
  logic [LOG2_WIN-1:0]      cnt_reg;
  logic                     taint_reg;
  logic                     stb_reg;
  logic signed [OUT_W-1:0]  mean_reg;
  logic                     mean_taint_reg;

  logic                     accept;
  logic                     wrap;
  logic                     in_window;
  logic                     taint_now;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_mean;
  logic signed [OUT_W-1:0]  mean_sat;

  always_comb begin
    accept    = feat_valid && !clear;
    wrap      = accept && (cnt_reg == '1);
    // A window is open from its first accepted sample until its last one.
    in_window = accept || (cnt_reg != '0);
    taint_now = taint_reg || (freeze && in_window);
    acc_sum   = acc_reg + ACC_W'(feat_in);
    acc_mean  = acc_sum >>> LOG2_WIN;
    mean_sat  = OUT_W'(sat_resize(SAT_W'(acc_mean), OUT_W));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      taint_reg      <= 1'b0;
      stb_reg        <= 1'b0;
      mean_reg       <= '0;
      mean_taint_reg <= 1'b0;
    end else begin
      stb_reg   <= wrap;
      taint_reg <= wrap ? 1'b0 : taint_now;
      if (wrap) begin
        mean_reg       <= mean_sat;
        mean_taint_reg <= taint_now;
        acc_reg        <= '0;
        cnt_reg        <= '0;
      end else if (accept) begin
        acc_reg <= acc_sum;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign mean_stb   = stb_reg;
  assign mean       = mean_reg;
  assign mean_taint = mean_taint_reg;

endmodule

// File: rtl/feature_baseline_tracker.sv
// Per-feature baseline: folds clean window means into an EMA, discarding windows
// that overlapped a detection.
module feature_baseline_tracker
  import seizure_det_pkg::*;
#(
  parameter int IN_W      = FEAT_W,
  parameter int BASE_W    = seizure_det_pkg::BASE_W,
  parameter int LOG2_WIN  = 8,
  parameter int EMA_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IN_W-1:0]   feat_in,
  input  logic                     feat_valid,
  input  logic                     freeze,
  input  logic                     clear,
  output logic signed [BASE_W-1:0] base_out,
  output logic                     base_valid,
  output logic                     base_update,
  output logic                     win_discard
);

  logic                     mean_stb;
  logic signed [BASE_W-1:0] mean;
  logic                     mean_taint;

  tracker_state_t           state_reg;
  logic signed [BASE_W-1:0] base_reg;
  logic                     base_valid_reg;
  logic                     update_reg;
  logic                     discard_reg;

  logic signed [BASE_W:0]   diff;
  logic signed [BASE_W:0]   step;
  logic signed [BASE_W-1:0] ema_next;

  window_accum #(
    .IN_W     (IN_W),
    .OUT_W    (BASE_W),
    .LOG2_WIN (LOG2_WIN)
  ) u_window_accum (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .feat_in    (feat_in),
    .feat_valid (feat_valid),
    .freeze     (freeze),
    .mean_stb   (mean_stb),
    .mean       (mean),
    .mean_taint (mean_taint)
  );

  // The step lies between 0 and diff, so base + step stays between base and mean
  // and truncating back to BASE_W bits never wraps.
  always_comb begin
    diff     = {mean[BASE_W-1], mean} - {base_reg[BASE_W-1], base_reg};
    step     = diff >>> EMA_SHIFT;
    ema_next = BASE_W'({base_reg[BASE_W-1], base_reg} + step);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= WARMUP;
      base_reg       <= '0;
      base_valid_reg <= 1'b0;
      update_reg     <= 1'b0;
      discard_reg    <= 1'b0;
    end else begin
      update_reg  <= 1'b0;
      discard_reg <= 1'b0;
      if (clear) begin
        // Drops the mean waiting in the accumulator's output register too.
        state_reg      <= WARMUP;
        base_valid_reg <= 1'b0;
      end else if (mean_stb) begin
        if (mean_taint) begin
          discard_reg <= 1'b1;
        end else begin
          update_reg <= 1'b1;
          case (state_reg)
            WARMUP: begin
              base_reg       <= mean;
              base_valid_reg <= 1'b1;
              state_reg      <= TRACK;
            end
            default: begin
              base_reg <= ema_next;
            end
          endcase
        end
      end
    end
  end

  assign base_out    = base_reg;
  assign base_valid  = base_valid_reg;
  assign base_update = update_reg;
  assign win_discard = discard_reg;

endmodule

// File: tb/tb_feature_baseline_tracker.sv
// Directed bench for feature_baseline_tracker with 4-sample windows and EMA shift 1.
module tb_feature_baseline_tracker;

  localparam int IN_W      = 72;
  localparam int BASE_W    = 50;
  localparam int LOG2_WIN  = 2;
  localparam int EMA_SHIFT = 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic signed [IN_W-1:0]   feat_in = '0;
  logic                     feat_valid = 1'b0;
  logic                     freeze = 1'b0;
  logic                     clear = 1'b0;
  logic signed [BASE_W-1:0] base_out;
  logic                     base_valid;
  logic                     base_update;
  logic                     win_discard;

  int pass_cnt  = 0;
  int check_cnt = 0;

  feature_baseline_tracker #(
    .IN_W      (IN_W),
    .BASE_W    (BASE_W),
    .LOG2_WIN  (LOG2_WIN),
    .EMA_SHIFT (EMA_SHIFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .feat_in     (feat_in),
    .feat_valid  (feat_valid),
    .freeze      (freeze),
    .clear       (clear),
    .base_out    (base_out),
    .base_valid  (base_valid),
    .base_update (base_update),
    .win_discard (win_discard)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Feeds one 4-sample window and observes cycles n+1, n+2 and n+3.
  task automatic run_window(
    input  logic signed [IN_W-1:0] v0, v1, v2, v3,
    input  int                     gap,
    input  int                     frz_idx,
    input  logic                   clr_last,
    input  logic                   clr_n1,
    output logic                   pulse_n1,
    output logic                   upd,
    output logic                   disc,
    output logic signed [BASE_W-1:0] base,
    output logic                   bvalid,
    output logic                   pulse_after
  );
    logic signed [IN_W-1:0] vals [4];
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    for (int i = 0; i < 4; i++) begin
      feat_in    = vals[i];
      feat_valid = 1'b1;
      freeze     = (i == frz_idx);
      clear      = clr_last && (i == 3);
      step();
      feat_valid = 1'b0;
      freeze     = 1'b0;
      clear      = 1'b0;
      if (gap != 0 && i < 3) begin
        step();
      end
    end
    pulse_n1 = base_update | win_discard;
    clear    = clr_n1;
    step();
    clear    = 1'b0;
    upd      = base_update;
    disc     = win_discard;
    base     = base_out;
    bvalid   = base_valid;
    step();
    pulse_after = base_update | win_discard;
    $display("window %0d,%0d,%0d,%0d gap=%0d frz=%0d clr=%0b/%0b -> upd=%0b disc=%0b base=%0d valid=%0b",
             v0, v1, v2, v3, gap, frz_idx, clr_last, clr_n1, upd, disc, base, bvalid);
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++;
    if (base_out !== '0) $display("FAIL reset_base: got %0d expected 0", base_out);
    else pass_cnt++;
    check_cnt++;
    if (base_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", base_valid);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({base_update, win_discard} !== 2'b00)
      $display("FAIL reset_pulses: got %b expected 00", {base_update, win_discard});
    else pass_cnt++;
  endtask

  task automatic test_warmup(input int gap);
    logic p1, u, d, bv, pa;
    logic signed [BASE_W-1:0] b;
    run_window(10, 20, 30, 40, gap, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if (p1 !== 1'b0) $display("FAIL warmup_early_pulse: got %0b expected 0", p1);
    else pass_cnt++;
    check_cnt++;
    if ({u, d, bv} !== 3'b101) $display("FAIL warmup_flags: got upd/disc/valid=%b expected 101", {u, d, bv});
    else pass_cnt++;
    check_cnt++;
    if (b !== 50'sd25) $display("FAIL warmup_base: got %0d expected 25", b);
    else pass_cnt++;
    check_cnt++;
    if (pa !== 1'b0) $display("FAIL warmup_pulse_width: got %0b expected 0", pa);
    else pass_cnt++;
  endtask

  task automatic test_ema(input int gap);
    logic p1, u, d, bv, pa;
    logic signed [BASE_W-1:0] b;
    run_window(45, 45, 45, 45, gap, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if ({u, d} !== 2'b10 || b !== 50'sd35)
      $display("FAIL ema_up: got upd/disc=%b base=%0d expected 10 base=35", {u, d}, b);
    else pass_cnt++;
    run_window(30, 30, 30, 30, gap, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if ({u, d} !== 2'b10 || b !== 50'sd32)
      $display("FAIL ema_down: got upd/disc=%b base=%0d expected 10 base=32", {u, d}, b);
    else pass_cnt++;
  endtask

  task automatic test_freeze_track();
    logic p1, u, d, bv, pa;
    logic signed [BASE_W-1:0] b;
    run_window(50, 50, 50, 50, 0, 1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if ({u, d, bv} !== 3'b011 || b !== 50'sd32)
      $display("FAIL freeze_track: got upd/disc/valid=%b base=%0d expected 011 base=32", {u, d, bv}, b);
    else pass_cnt++;
    check_cnt++;
    if (pa !== 1'b0) $display("FAIL freeze_pulse_width: got %0b expected 0", pa);
    else pass_cnt++;
    // The following clean window must not inherit the taint.
    run_window(40, 40, 40, 40, 0, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if ({u, d} !== 2'b10 || b !== 50'sd36)
      $display("FAIL freeze_recover: got upd/disc=%b base=%0d expected 10 base=36", {u, d}, b);
    else pass_cnt++;
  endtask

  task automatic test_freeze_warmup();
    logic p1, u, d, bv, pa;
    logic signed [BASE_W-1:0] b;
    do_reset();
    run_window(10, 20, 30, 40, 0, 2, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if ({u, d, bv} !== 3'b010 || b !== 50'sd0)
      $display("FAIL freeze_warmup: got upd/disc/valid=%b base=%0d expected 010 base=0", {u, d, bv}, b);
    else pass_cnt++;
    // freeze with no window open is ignored
    freeze = 1'b1;
    step();
    freeze = 1'b0;
    run_window(8, 8, 8, 8, 0, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if ({u, d, bv} !== 3'b101 || b !== 50'sd8)
      $display("FAIL freeze_idle: got upd/disc/valid=%b base=%0d expected 101 base=8", {u, d, bv}, b);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic p1, u, d, bv, pa;
    logic signed [BASE_W-1:0] b;
    logic signed [IN_W-1:0]   big;
    logic signed [BASE_W-1:0] max_b;
    logic signed [BASE_W-1:0] min_b;
    big   = 72'sd1 <<< 60;
    max_b = {1'b0, {(BASE_W-1){1'b1}}};
    min_b = {1'b1, {(BASE_W-1){1'b0}}};
    do_reset();
    run_window(big, big, big, big, 0, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if (b !== max_b || bv !== 1'b1) $display("FAIL sat_pos: got %0d valid=%0b expected %0d valid=1", b, bv, max_b);
    else pass_cnt++;
    do_reset();
    run_window(-big, -big, -big, -big, 0, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if (b !== min_b || bv !== 1'b1) $display("FAIL sat_neg: got %0d valid=%0b expected %0d valid=1", b, bv, min_b);
    else pass_cnt++;
  endtask

  task automatic test_clear_race();
    logic p1, u, d, bv, pa;
    logic signed [BASE_W-1:0] b;
    do_reset();
    run_window(10, 20, 30, 40, 0, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    run_window(45, 45, 45, 45, 0, -1, 1'b1, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if ({p1, u, d, pa} !== 4'b0000) $display("FAIL clear_race_pulses: got %b expected 0000", {p1, u, d, pa});
    else pass_cnt++;
    check_cnt++;
    if (bv !== 1'b0 || b !== 50'sd25) $display("FAIL clear_race_hold: got valid=%0b base=%0d expected valid=0 base=25", bv, b);
    else pass_cnt++;
    run_window(8, 8, 8, 8, 0, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if ({u, bv} !== 2'b11 || b !== 50'sd8) $display("FAIL clear_relearn: got upd/valid=%b base=%0d expected 11 base=8", {u, bv}, b);
    else pass_cnt++;
    // Back in TRACK: 12 moves the base by (12-8)>>>1 = 2.
    run_window(12, 12, 12, 12, 0, -1, 1'b0, 1'b0, p1, u, d, b, bv, pa);
    check_cnt++;
    if (u !== 1'b1 || b !== 50'sd10) $display("FAIL clear_track: got upd=%0b base=%0d expected 1 base=10", u, b);
    else pass_cnt++;
    // clear while the mean is in flight cancels it
    run_window(20, 20, 20, 20, 0, -1, 1'b0, 1'b1, p1, u, d, b, bv, pa);
    check_cnt++;
    if ({u, d, bv, pa} !== 4'b0000 || b !== 50'sd10)
      $display("FAIL clear_inflight: got upd/disc/valid/after=%b base=%0d expected 0000 base=10", {u, d, bv, pa}, b);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int vals [8] = '{10, 20, 30, 40, 45, 45, 45, 45};
    int n_upd = 0;
    int first_cyc = -1;
    int second_cyc = -1;
    logic signed [BASE_W-1:0] b_first = '0;
    logic signed [BASE_W-1:0] b_second = '0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      feat_valid = (c < 8);
      feat_in    = (c < 8) ? IN_W'(vals[c]) : '0;
      step();
      if (base_update) begin
        n_upd++;
        if (n_upd == 1) begin first_cyc = c; b_first = base_out; end
        if (n_upd == 2) begin second_cyc = c; b_second = base_out; end
      end
    end
    feat_valid = 1'b0;
    $display("back_to_back: updates=%0d at %0d,%0d bases=%0d,%0d", n_upd, first_cyc, second_cyc, b_first, b_second);
    check_cnt++;
    if (n_upd !== 2) $display("FAIL b2b_count: got %0d expected 2", n_upd);
    else pass_cnt++;
    check_cnt++;
    if (b_first !== 50'sd25 || b_second !== 50'sd35)
      $display("FAIL b2b_bases: got %0d,%0d expected 25,35", b_first, b_second);
    else pass_cnt++;
    check_cnt++;
    if (second_cyc - first_cyc !== 4) $display("FAIL b2b_spacing: got %0d expected 4", second_cyc - first_cyc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_warmup(0);
    test_ema(0);
    test_freeze_track();
    do_reset();
    test_warmup(1);
    test_ema(1);
    test_freeze_warmup();
    test_saturation();
    test_clear_race();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
